// File: rtl/ex_mem_reg.sv
// ex_mem_reg: pipeline register between the execute and memory stages.
// It captures the ALU result, the store data and the memory/writeback controls
// on each enabled edge. It holds its contents on a stall and loads an all-zero
// bubble on a flush. It suppresses misaligned loads and stores before they
// reach data memory. It forwards writeback-stage results into the store data,
// so that a load followed by a dependent store writes the correct value.
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-low reset
//   en, flush           0 = stall (hold); flush inserts a bubble and wins over en
//   *_ex                execute-stage operands and controls
//   wb_rd, wb_reg_file_wb, wb_data
//                       writeback-stage register write, used for store-data forwarding
//   *_mem               registered memory-stage outputs
//   mem_addr_mem        low ADDR_W bits of the registered ALU result
//   misalign_mem        the instruction now in MEM had a misaligned access
module ex_mem_reg #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic [31:0]       alu_result_ex,
  input  logic [31:0]       rs2_data_ex,
  input  logic [4:0]        rs2_ex,
  input  logic [4:0]        rd_ex,
  input  logic              mem_write_ex,
  input  logic              memtoreg_ex,
  input  logic [2:0]        mem_load_type_ex,
  input  logic [1:0]        mem_store_type_ex,
  input  logic              wb_reg_file_ex,
  input  logic [4:0]        wb_rd,
  input  logic              wb_reg_file_wb,
  input  logic [31:0]       wb_data,
  output logic [31:0]       alu_result_mem,
  output logic [ADDR_W-1:0] mem_addr_mem,
  output logic [31:0]       rs2_data_mem,
  output logic [4:0]        rd_mem,
  output logic              mem_write_mem,
  output logic              memtoreg_mem,
  output logic [2:0]        mem_load_type_mem,
  output logic [1:0]        mem_store_type_mem,
  output logic              wb_reg_file_mem,
  output logic              misalign_mem
);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  acc_size_t   acc_size;
  logic        misalign_ex;
  logic [31:0] rs2_data_q;
  logic [4:0]  rs2_q;
  logic        fwd_hit;

  // The access size comes from the store type for stores and from the load
  // type otherwise. Unlisted encodings fall back to word.
  always_comb begin
    acc_size = SZ_WORD;
    if (mem_write_ex) begin
      case (mem_store_type_ex)
        2'b00:   acc_size = SZ_BYTE;
        2'b01:   acc_size = SZ_HALF;
        default: acc_size = SZ_WORD;
      endcase
    end else begin
      case (mem_load_type_ex)
        3'b000, 3'b100: acc_size = SZ_BYTE;
        3'b001, 3'b101: acc_size = SZ_HALF;
        default:        acc_size = SZ_WORD;
      endcase
    end
  end

  always_comb begin
    misalign_ex = 1'b0;
    if (mem_write_ex || memtoreg_ex) begin
      case (acc_size)
        SZ_HALF: misalign_ex = alu_result_ex[0];
        SZ_WORD: misalign_ex = (alu_result_ex[1:0] != 2'b00);
        default: misalign_ex = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result_mem     <= '0;
      rs2_data_q         <= '0;
      rs2_q              <= '0;
      rd_mem             <= '0;
      mem_write_mem      <= 1'b0;
      memtoreg_mem       <= 1'b0;
      mem_load_type_mem  <= '0;
      mem_store_type_mem <= '0;
      wb_reg_file_mem    <= 1'b0;
      misalign_mem       <= 1'b0;
    end else if (flush) begin
      alu_result_mem     <= '0;
      rs2_data_q         <= '0;
      rs2_q              <= '0;
      rd_mem             <= '0;
      mem_write_mem      <= 1'b0;
      memtoreg_mem       <= 1'b0;
      mem_load_type_mem  <= '0;
      mem_store_type_mem <= '0;
      wb_reg_file_mem    <= 1'b0;
      misalign_mem       <= 1'b0;
    end else if (en) begin
      alu_result_mem     <= alu_result_ex;
      rs2_data_q         <= rs2_data_ex;
      rs2_q              <= rs2_ex;
      rd_mem             <= rd_ex;
      mem_write_mem      <= mem_write_ex & ~misalign_ex;
      memtoreg_mem       <= memtoreg_ex & ~misalign_ex;
      mem_load_type_mem  <= mem_load_type_ex;
      mem_store_type_mem <= mem_store_type_ex;
      // A misaligned load must not write back. A misaligned store keeps its
      // (normally zero) writeback flag.
      wb_reg_file_mem    <= wb_reg_file_ex & ~(misalign_ex & memtoreg_ex);
      misalign_mem       <= misalign_ex;
    end
  end

  assign mem_addr_mem = alu_result_mem[ADDR_W-1:0];

  // mem_write_mem is already cleared for a misaligned store, so a suppressed
  // store never forwards.
  assign fwd_hit = mem_write_mem & wb_reg_file_wb & (wb_rd != 5'd0) & (wb_rd == rs2_q);
  assign rs2_data_mem = fwd_hit ? wb_data : rs2_data_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

  logic        clk;
  logic        rst;
  logic        en;
  logic        flush;
  logic [31:0] alu_result_ex;
  logic [31:0] rs2_data_ex;
  logic [4:0]  rs2_ex;
  logic [4:0]  rd_ex;
  logic        mem_write_ex;
  logic        memtoreg_ex;
  logic [2:0]  mem_load_type_ex;
  logic [1:0]  mem_store_type_ex;
  logic        wb_reg_file_ex;
  logic [4:0]  wb_rd;
  logic        wb_reg_file_wb;
  logic [31:0] wb_data;
  logic [31:0] alu_result_mem;
  logic [9:0]  mem_addr_mem;
  logic [31:0] rs2_data_mem;
  logic [4:0]  rd_mem;
  logic        mem_write_mem;
  logic        memtoreg_mem;
  logic [2:0]  mem_load_type_mem;
  logic [1:0]  mem_store_type_mem;
  logic        wb_reg_file_mem;
  logic        misalign_mem;

  int n_checks = 0;
  int n_fail   = 0;

  ex_mem_reg #(.ADDR_W(10)) dut (
    .clk                (clk),
    .rst                (rst),
    .en                 (en),
    .flush              (flush),
    .alu_result_ex      (alu_result_ex),
    .rs2_data_ex        (rs2_data_ex),
    .rs2_ex             (rs2_ex),
    .rd_ex              (rd_ex),
    .mem_write_ex       (mem_write_ex),
    .memtoreg_ex        (memtoreg_ex),
    .mem_load_type_ex   (mem_load_type_ex),
    .mem_store_type_ex  (mem_store_type_ex),
    .wb_reg_file_ex     (wb_reg_file_ex),
    .wb_rd              (wb_rd),
    .wb_reg_file_wb     (wb_reg_file_wb),
    .wb_data            (wb_data),
    .alu_result_mem     (alu_result_mem),
    .mem_addr_mem       (mem_addr_mem),
    .rs2_data_mem       (rs2_data_mem),
    .rd_mem             (rd_mem),
    .mem_write_mem      (mem_write_mem),
    .memtoreg_mem       (memtoreg_mem),
    .mem_load_type_mem  (mem_load_type_mem),
    .mem_store_type_mem (mem_store_type_mem),
    .wb_reg_file_mem    (wb_reg_file_mem),
    .misalign_mem       (misalign_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_bubble(input string tag);
    check_eq({tag, ".alu"},   alu_result_mem, 32'h0);
    check_eq({tag, ".addr"},  {22'd0, mem_addr_mem}, 32'h0);
    check_eq({tag, ".rs2d"},  rs2_data_mem, 32'h0);
    check_eq({tag, ".rd"},    {27'd0, rd_mem}, 32'h0);
    check_eq({tag, ".mw"},    {31'd0, mem_write_mem}, 32'h0);
    check_eq({tag, ".mr"},    {31'd0, memtoreg_mem}, 32'h0);
    check_eq({tag, ".lt"},    {29'd0, mem_load_type_mem}, 32'h0);
    check_eq({tag, ".st"},    {30'd0, mem_store_type_mem}, 32'h0);
    check_eq({tag, ".wbf"},   {31'd0, wb_reg_file_mem}, 32'h0);
    check_eq({tag, ".mis"},   {31'd0, misalign_mem}, 32'h0);
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] d, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mw, input logic mr,
                       input logic [2:0] lt, input logic [1:0] st, input logic wbf);
    alu_result_ex     = alu;
    rs2_data_ex       = d;
    rs2_ex            = rs2;
    rd_ex             = rd;
    mem_write_ex      = mw;
    memtoreg_ex       = mr;
    mem_load_type_ex  = lt;
    mem_store_type_ex = st;
    wb_reg_file_ex    = wbf;
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; flush = 1'b0;
    wb_rd = 5'd0; wb_reg_file_wb = 1'b0; wb_data = 32'h0;
    drive(32'hFFFF_FFFF, 32'hCAFE_F00D, 5'd9, 5'd9, 1'b1, 1'b1, 3'b010, 2'b10, 1'b1);

    // Reset holds the bubble while the clock runs.
    step(); step(); step();
    check_bubble("reset");

    // First capture after release: SW to 0x104.
    rst = 1'b1;
    drive(32'h0000_0104, 32'hDEAD_BEEF, 5'd3, 5'd0, 1'b1, 1'b0, 3'b000, 2'b10, 1'b0);
    step();
    check_eq("sw.mw",   {31'd0, mem_write_mem}, 32'd1);
    check_eq("sw.addr", {22'd0, mem_addr_mem}, 32'h104);
    check_eq("sw.rs2d", rs2_data_mem, 32'hDEAD_BEEF);
    check_eq("sw.mis",  {31'd0, misalign_mem}, 32'd0);
    check_eq("sw.st",   {30'd0, mem_store_type_mem}, 32'd2);

    // LW rd=5, then stall for 3 edges with different EX inputs.
    drive(32'h0000_0200, 32'h0, 5'd0, 5'd5, 1'b0, 1'b1, 3'b010, 2'b00, 1'b1);
    step();
    check_eq("lw.mr",  {31'd0, memtoreg_mem}, 32'd1);
    check_eq("lw.rd",  {27'd0, rd_mem}, 32'd5);
    check_eq("lw.wbf", {31'd0, wb_reg_file_mem}, 32'd1);
    check_eq("lw.mw",  {31'd0, mem_write_mem}, 32'd0);
    en = 1'b0;
    drive(32'h0000_0333, 32'h5555_5555, 5'd1, 5'd17, 1'b1, 1'b0, 3'b001, 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) step();
    check_eq("stall.alu", alu_result_mem, 32'h200);
    check_eq("stall.rd",  {27'd0, rd_mem}, 32'd5);
    check_eq("stall.mr",  {31'd0, memtoreg_mem}, 32'd1);
    check_eq("stall.lt",  {29'd0, mem_load_type_mem}, 32'd2);
    check_eq("stall.mw",  {31'd0, mem_write_mem}, 32'd0);

    // Flush while stalled wins.
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_bubble("flush");

    // LH at 0x3 is misaligned; misalign stays high across a stall.
    en = 1'b1;
    drive(32'h0000_0003, 32'h0, 5'd0, 5'd12, 1'b0, 1'b1, 3'b001, 2'b00, 1'b1);
    step();
    check_eq("lh3.mr",   {31'd0, memtoreg_mem}, 32'd0);
    check_eq("lh3.wbf",  {31'd0, wb_reg_file_mem}, 32'd0);
    check_eq("lh3.mis",  {31'd0, misalign_mem}, 32'd1);
    check_eq("lh3.rd",   {27'd0, rd_mem}, 32'd12);
    check_eq("lh3.addr", {22'd0, mem_addr_mem}, 32'h3);
    en = 1'b0;
    step();
    check_eq("lh3.stall.mis", {31'd0, misalign_mem}, 32'd1);
    en = 1'b1;

    // LHU at 0x2 is aligned.
    drive(32'h0000_0002, 32'h0, 5'd0, 5'd13, 1'b0, 1'b1, 3'b101, 2'b00, 1'b1);
    step();
    check_eq("lhu2.mr",  {31'd0, memtoreg_mem}, 32'd1);
    check_eq("lhu2.mis", {31'd0, misalign_mem}, 32'd0);

    // SB at 0x3 is never misaligned.
    drive(32'h0000_0003, 32'h0000_00AB, 5'd4, 5'd0, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0);
    step();
    check_eq("sb3.mw",  {31'd0, mem_write_mem}, 32'd1);
    check_eq("sb3.mis", {31'd0, misalign_mem}, 32'd0);

    // SW at 0x2 is misaligned.
    drive(32'h0000_0002, 32'h0000_0011, 5'd4, 5'd0, 1'b1, 1'b0, 3'b000, 2'b10, 1'b0);
    step();
    check_eq("sw2.mw",  {31'd0, mem_write_mem}, 32'd0);
    check_eq("sw2.mis", {31'd0, misalign_mem}, 32'd1);

    // Unlisted store type 11 is checked as a word.
    drive(32'h0000_0001, 32'h0, 5'd4, 5'd0, 1'b1, 1'b0, 3'b000, 2'b11, 1'b0);
    step();
    check_eq("st11.mis", {31'd0, misalign_mem}, 32'd1);

    // Non-memory instruction with an odd ALU result is not a memory access.
    drive(32'h0000_0007, 32'h0, 5'd0, 5'd8, 1'b0, 1'b0, 3'b010, 2'b10, 1'b1);
    step();
    check_eq("alu.mis", {31'd0, misalign_mem}, 32'd0);
    check_eq("alu.wbf", {31'd0, wb_reg_file_mem}, 32'd1);

    // Forwarding: SW with rs2=7 held in MEM while WB inputs change.
    drive(32'h0000_0010, 32'hAAAA_5555, 5'd7, 5'd0, 1'b1, 1'b0, 3'b000, 2'b10, 1'b0);
    step();
    en = 1'b0;
    wb_rd = 5'd7; wb_reg_file_wb = 1'b1; wb_data = 32'h1234_5678;
    #1;
    check_eq("fwd.hit", rs2_data_mem, 32'h1234_5678);
    wb_rd = 5'd0;
    #1;
    check_eq("fwd.rd0", rs2_data_mem, 32'hAAAA_5555);
    wb_rd = 5'd7; wb_reg_file_wb = 1'b0;
    #1;
    check_eq("fwd.nowb", rs2_data_mem, 32'hAAAA_5555);
    wb_rd = 5'd6; wb_reg_file_wb = 1'b1;
    #1;
    check_eq("fwd.other", rs2_data_mem, 32'hAAAA_5555);
    wb_rd = 5'd7;
    step();
    check_eq("fwd.stall", rs2_data_mem, 32'h1234_5678);
    en = 1'b1;

    // Misaligned store with matching WB rd: no forwarding.
    drive(32'h0000_0006, 32'h1111_2222, 5'd7, 5'd0, 1'b1, 1'b0, 3'b000, 2'b10, 1'b0);
    step();
    check_eq("fwd.mis", rs2_data_mem, 32'h1111_2222);

    // Load (non-store) in MEM with matching WB rd: no forwarding.
    drive(32'h0000_0008, 32'h3333_4444, 5'd7, 5'd2, 1'b0, 1'b1, 3'b010, 2'b00, 1'b1);
    step();
    check_eq("fwd.load", rs2_data_mem, 32'h3333_4444);
    wb_reg_file_wb = 1'b0; wb_rd = 5'd0;

    // Async reset during a stall clears outputs before the next edge.
    drive(32'h0000_0104, 32'h7777_8888, 5'd3, 5'd9, 1'b1, 1'b0, 3'b000, 2'b10, 1'b1);
    step();
    check_eq("pre.mw", {31'd0, mem_write_mem}, 32'd1);
    en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_bubble("arst");
    #1;
    rst = 1'b1;
    en = 1'b1;
    step();
    check_eq("post.rs2d", rs2_data_mem, 32'h7777_8888);
    check_eq("post.rd",   {27'd0, rd_mem}, 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
